// File: rtl/reg_rename_file.sv
// -----------------------------------------------------------------------------
// reg_rename_file
//   Architectural register file with per-register rename status (busy bit plus
//   ROB tag). Rename and commit traffic from the ROB update the state at the
//   clock edge. Operand lookups are combinational and return either the
//   committed value (ready = 1) or the pending producer's ROB tag,
//   zero-extended to XLEN (ready = 0).
//
//   Optional feature macro: REGFILE_COMMIT_BYPASS_EN
//     When defined, a lookup that hits the register being retired in the
//     current cycle returns commit_val combinationally with ready = 1.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   rdy                       global ready; all state holds while low
//   rename_en/_rd/_tag        allocate a new producer (ROB rear) for rename_rd
//   commit_en/_rd/_tag/_val   retire a result (ROB front) into commit_rd
//   flush                     mispredict recovery; clears every busy bit
//   rs1_addr, rs2_addr        lookup indices
//   rs1_ready/_val,
//   rs2_ready/_val            lookup results (value, or tag when not ready)
// -----------------------------------------------------------------------------
module reg_rename_file #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rename_en,
  input  logic [4:0]       rename_rd,
  input  logic [TAG_W-1:0] rename_tag,
  input  logic             commit_en,
  input  logic [4:0]       commit_rd,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [XLEN-1:0]  commit_val,
  input  logic             flush,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic             rs1_ready,
  output logic [XLEN-1:0]  rs1_val,
  output logic             rs2_ready,
  output logic [XLEN-1:0]  rs2_val
);

  logic [XLEN-1:0]  val_r  [NREG];
  logic [NREG-1:0]  busy_r;
  logic [TAG_W-1:0] tag_r  [NREG];

  logic rename_go_s;
  logic commit_go_s;
  logic flush_go_s;
  logic bypass_go_s;

  // Resolve a lookup for one source port. x0 is hard-wired to ready/zero.
  // While a commit is in flight, the bypass (when built in) forwards the
  // retiring value to any busy register whose pending tag matches.
  function automatic logic [XLEN:0] lookup(
    input logic [4:0]       addr,
    input logic             busy,
    input logic [TAG_W-1:0] tag,
    input logic [XLEN-1:0]  val,
    input logic             byp_go,
    input logic [TAG_W-1:0] byp_tag,
    input logic [XLEN-1:0]  byp_val
  );
    logic [XLEN:0] res;
    if (addr == 5'd0) begin
      res = {1'b1, {XLEN{1'b0}}};
    end else if (busy) begin
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (byp_go && (tag == byp_tag)) begin
        res = {1'b1, byp_val};
      end else begin
        res = {1'b0, {(XLEN-TAG_W){1'b0}}, tag};
      end
`else
      res = {1'b0, {(XLEN-TAG_W){1'b0}}, tag};
`endif
    end else begin
      res = {1'b1, val};
    end
    return res;
  endfunction

  // Qualify the incoming requests: flush suppresses same-cycle renames, and
  // nothing takes effect while rdy is low. x0 is never a write target.
  always_comb begin
    rename_go_s = rename_en & rdy & ~flush & (rename_rd != 5'd0);
    commit_go_s = commit_en & rdy & (commit_rd != 5'd0);
    flush_go_s  = flush & rdy;
    bypass_go_s = commit_en & rdy;
  end

  // Register state update: commit always writes the value; the busy bit is
  // resolved with flush > rename > matching commit, so the youngest producer
  // keeps ownership of the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= '0;
      for (int i = 0; i < NREG; i++) begin
        val_r[i] <= '0;
        tag_r[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (commit_go_s && (commit_rd == 5'(i))) begin
          val_r[i] <= commit_val;
        end
        if (flush_go_s) begin
          busy_r[i] <= 1'b0;
        end else if (rename_go_s && (rename_rd == 5'(i))) begin
          busy_r[i] <= 1'b1;
          tag_r[i]  <= rename_tag;
        end else if (commit_go_s && (commit_rd == 5'(i)) && busy_r[i] &&
                     (tag_r[i] == commit_tag)) begin
          busy_r[i] <= 1'b0;
        end
      end
    end
  end

  // Combinational operand lookups on the current (pre-edge) state.
  always_comb begin
    {rs1_ready, rs1_val} = lookup(rs1_addr, busy_r[rs1_addr], tag_r[rs1_addr],
                                  val_r[rs1_addr], bypass_go_s, commit_tag,
                                  commit_val);
    {rs2_ready, rs2_val} = lookup(rs2_addr, busy_r[rs2_addr], tag_r[rs2_addr],
                                  val_r[rs2_addr], bypass_go_s, commit_tag,
                                  commit_val);
  end

endmodule
